digital_tube_ctrl: RTL and testbench

Memory-mapped 8-digit seven-segment display controller on the CPU bridge; the output-direction counterpart of the DIP-switch input device. The CPU writes a 32-bit value (eight hex nibbles) and a control word. The block time-multiplexes two 4-digit tube groups with a shared scan counter and drives registered segment/select lines. Both registers can be read back over the same bus port.

---
 rtl/digital_tube_ctrl.sv | 141 ++++++++++++++
 tb/tb_digital_tube_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/digital_tube_ctrl.sv
// Bus-mapped 8-digit seven-segment controller: two 4-digit groups share one scan index.
// Optional leading-zero blanking is enabled by defining DIGITAL_TUBE_LZB_EN.
module digital_tube_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] DATA_ADDR = 32'h7f50,
  parameter logic [31:0] CTRL_ADDR = 32'h7f54
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [3:0]  byteen,
  input  logic [31:0] WD,
  output logic [31:0] DTout,
  output logic [7:0]  seg0,
  output logic [3:0]  sel0,
  output logic [7:0]  seg1,
  output logic [3:0]  sel1
);

  localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

  logic [31:0] data_q, data_d;
  logic        en_q, en_d;
  logic [7:0]  dpm_q, dpm_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seg0_q, seg0_d, seg1_q, seg1_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    data_d = data_q;
    en_d   = en_q;
    dpm_d  = dpm_q;
    if (WE && Addr == DATA_ADDR) begin
      for (int unsigned n = 0; n < 4; n++)
        if (byteen[n]) data_d[8*n +: 8] = WD[8*n +: 8];
    end
    if (WE && Addr == CTRL_ADDR) begin
      if (byteen[0]) en_d  = WD[0];
      if (byteen[1]) dpm_d = WD[15:8];
    end
  end

  always_comb begin
    cnt_d = cnt_q + 20'd1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

`ifdef DIGITAL_TUBE_LZB_EN
  // Running AND from the top nibble down: digit i is blank when nibbles 7..i are all zero.
  always_comb begin
    logic z;
    blank = '0;
    z     = 1'b1;
    for (int unsigned i = 7; i >= 1; i--) begin
      z        = z & (data_q[4*i +: 4] == 4'h0);
      blank[i] = z;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    logic [3:0] nib0, nib1;
    logic [6:0] gl0, gl1;
    nib0   = data_q[4*idx_q +: 4];
    nib1   = data_q[16 + 4*idx_q +: 4];
    gl0    = blank[{1'b0, idx_q}] ? 7'h00 : hex7(nib0);
    gl1    = blank[{1'b1, idx_q}] ? 7'h00 : hex7(nib1);
    seg0_d = ~{dpm_q[{1'b0, idx_q}], gl0};
    seg1_d = ~{dpm_q[{1'b1, idx_q}], gl1};
    sel_d  = 4'b0001 << idx_q;
    if (!en_q) begin
      seg0_d = '1;
      seg1_d = '1;
      sel_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      en_q   <= 1'b1;
      dpm_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg0_q <= '1;
      seg1_q <= '1;
      sel_q  <= '0;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
      dpm_q  <= dpm_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    DTout = '0;
    if (Addr == DATA_ADDR)      DTout = data_q;
    else if (Addr == CTRL_ADDR) DTout = {16'h0000, dpm_q, 7'h00, en_q};
  end

  assign seg0 = seg0_q;
  assign seg1 = seg1_q;
  assign sel0 = sel_q;
  assign sel1 = sel_q;

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Directed bench for digital_tube_ctrl with SCAN_DIV=4; define DIGITAL_TUBE_LZB_EN to match the RTL build.
module tb_digital_tube_ctrl;

  localparam logic [31:0] DA = 32'h7f50;
  localparam logic [31:0] CA = 32'h7f54;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [3:0]  byteen;
  logic [31:0] WD;
  logic [31:0] DTout;
  logic [7:0]  seg0, seg1;
  logic [3:0]  sel0, sel1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_s0 [4] = '{8'hF8, 8'h82, 8'h92, 8'h99};
  logic [7:0] exp_s1 [4] = '{8'h83, 8'h88, 8'h90, 8'h80};
  logic [7:0] lz_hi;

  digital_tube_ctrl #(.SCAN_DIV(4), .DATA_ADDR(DA), .CTRL_ADDR(CA)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .byteen(byteen), .WD(WD),
    .DTout(DTout), .seg0(seg0), .sel0(sel0), .seg1(seg1), .sel1(sel1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    WE = 1'b1; Addr = a; WD = d; byteen = be;
    @(negedge clk);
    WE = 1'b0;
    #1;
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int n;
    n = 0;
    while (sel0 !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_sel", {28'h0, sel0}, {28'h0, s});
  endtask

  initial begin
`ifdef DIGITAL_TUBE_LZB_EN
    lz_hi = 8'hFF;
`else
    lz_hi = 8'hC0;
`endif
    reset = 1'b0; WE = 1'b0; Addr = CA; byteen = 4'h0; WD = '0;
    @(negedge clk);
    chk("rst_seg0", {24'h0, seg0}, 32'hFF);
    chk("rst_seg1", {24'h0, seg1}, 32'hFF);
    chk("rst_sel0", {28'h0, sel0}, 32'h0);
    chk("rst_sel1", {28'h0, sel1}, 32'h0);
    chk("rst_ctrl", DTout, 32'h1);
    Addr = DA; #1;
    chk("rst_data", DTout, 32'h0);

    // Release reset and write data in the same cycle; first edge shows digit 0 of old data.
    reset = 1'b1; WE = 1'b1; Addr = DA; byteen = 4'hF; WD = 32'h89AB4567;
    @(negedge clk);
    chk("first_sel0", {28'h0, sel0}, 32'h1);
    chk("first_sel1", {28'h0, sel1}, 32'h1);
    chk("first_seg0", {24'h0, seg0}, 32'hC0);
    WE = 1'b0; #1;
    chk("data_rd", DTout, 32'h89AB4567);

    for (int e = 2; e <= 17; e++) begin
      int ix;
      @(negedge clk);
      ix = ((e - 1) / 4) % 4;
      chk("scan_sel", {28'h0, sel0}, 32'h1 << ix);
      chk("scan_seg0", {24'h0, seg0}, {24'h0, exp_s0[ix]});
      chk("scan_seg1", {24'h0, seg1}, {24'h0, exp_s1[ix]});
    end

    wr(DA, 32'h11223344, 4'hF);
    wr(DA, 32'hFFFFFFFF, 4'b0101);
    chk("byteen", DTout, 32'h11FF33FF);
    wr(32'h7f58, 32'h0, 4'hF);
    Addr = DA; #1;
    chk("bad_addr_wr", DTout, 32'h11FF33FF);
    Addr = 32'h7f58; #1;
    chk("bad_addr_rd", DTout, 32'h0);

    wr(CA, 32'h00000100, 4'hF);
    chk("ctrl_rd", DTout, 32'h00000100);
    @(negedge clk);
    chk("dis_seg0", {24'h0, seg0}, 32'hFF);
    chk("dis_seg1", {24'h0, seg1}, 32'hFF);
    chk("dis_sel0", {28'h0, sel0}, 32'h0);
    chk("dis_sel1", {28'h0, sel1}, 32'h0);
    wr(CA, 32'hFFFFFFFF, 4'b0010);
    chk("ctrl_be1", DTout, 32'h0000FF00);
    wr(CA, 32'hFFFFFFFF, 4'b1101);
    chk("ctrl_mask", DTout, 32'h0000FF01);
    wr(CA, 32'h00000101, 4'hF);
    chk("ctrl_101", DTout, 32'h00000101);
    @(negedge clk);
    wait_sel(4'b0001);
    chk("dp_seg0", {24'h0, seg0}, 32'h0E);
    chk("dp_seg1", {24'h0, seg1}, 32'h8E);

    wr(CA, 32'h00000001, 4'hF);
    wr(DA, 32'h00000120, 4'hF);
    @(negedge clk);
    wait_sel(4'b0001);
    chk("lz_d0", {24'h0, seg0}, 32'hC0);
    chk("lz_d4", {24'h0, seg1}, {24'h0, lz_hi});
    wait_sel(4'b0010);
    chk("lz_d1", {24'h0, seg0}, 32'hA4);
    chk("lz_d5", {24'h0, seg1}, {24'h0, lz_hi});
    wait_sel(4'b0100);
    chk("lz_d2", {24'h0, seg0}, 32'hF9);
    wait_sel(4'b1000);
    chk("lz_d3", {24'h0, seg0}, {24'h0, lz_hi});
    chk("lz_d7", {24'h0, seg1}, {24'h0, lz_hi});

    wait_sel(4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("arst_seg0", {24'h0, seg0}, 32'hFF);
    chk("arst_seg1", {24'h0, seg1}, 32'hFF);
    chk("arst_sel0", {28'h0, sel0}, 32'h0);
    chk("arst_sel1", {28'h0, sel1}, 32'h0);
    Addr = DA; #1;
    chk("arst_data", DTout, 32'h0);
    Addr = CA; #1;
    chk("arst_ctrl", DTout, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
